// File: rtl/prefetch.sv
`default_nettype none
// prefetch: linear code prefetch queue of up to five dwords feeding a 16-byte decode window.
// Revision: 1.0
module prefetch #(
   parameter logic [31:0] RESET_IP = 32'h000FFFF0
) (
   input  logic          clock,
   input  logic          reset,
   output logic [127:0]  o_codebuf,
   output logic [1:0]    o_align,
   output logic          o_valid,
   output logic [31:0]   o_ip,
   input  logic          i_consume,
   input  logic [4:0]    i_consume_len,
   input  logic          i_jump,
   input  logic [31:0]   i_jump_ip,
   output logic [31:0]   o_addr,
   output logic          o_rd,
   input  logic [31:0]   i_data,
   input  logic          i_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state;
   logic [2:0]  count;
   logic [31:0] fptr;
   logic [31:0] queue     [0:4];
   logic [31:0] queue_nxt [0:4];
   logic [2:0]  count_nxt;
   logic [2:0]  drop;
   logic [2:0]  tail;
   logic [4:0]  span;
   logic        take;
   logic        fill;

   assign o_valid = (count >= 3'd4);

   // Dwords beyond the filled part of the queue read as zero.
   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_win
         assign o_codebuf[32*g +: 32] = (count > 3'(g)) ? queue[g] : 32'd0;
      end
   endgenerate

   always_comb begin
      span      = {3'b000, o_align} + i_consume_len;
      take      = i_consume && o_valid && (i_consume_len != 5'd0) &&
                  (i_consume_len <= (5'd16 - {3'b000, o_align}));
      drop      = take ? span[4:2] : 3'd0;
      fill      = (state == FETCH) && i_ready;
      tail      = count - drop;
      count_nxt = tail + {2'b00, fill};
      for (int i = 0; i < 5; i++) begin
         queue_nxt[i] = 32'd0;
         for (int j = 0; j < 5; j++) begin
            if (j - i == int'(drop)) queue_nxt[i] = queue[j];
         end
      end
      // Captured dword lands just past the surviving entries.
      for (int j = 0; j < 5; j++) begin
         if (fill && (3'(j) == tail)) queue_nxt[j] = i_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= 3'd0;
         o_align <= RESET_IP[1:0];
         o_ip    <= RESET_IP;
         fptr    <= {RESET_IP[31:2], 2'b00};
         o_rd    <= 1'b0;
         o_addr  <= 32'd0;
         for (int i = 0; i < 5; i++) queue[i] <= 32'd0;
      end else if (i_jump) begin
         count   <= 3'd0;
         o_align <= i_jump_ip[1:0];
         o_ip    <= i_jump_ip;
         fptr    <= {i_jump_ip[31:2], 2'b00};
         // An outstanding read must complete before the new stream starts.
         if ((state == IDLE) || i_ready) begin
            state  <= FETCH;
            o_rd   <= 1'b1;
            o_addr <= {i_jump_ip[31:2], 2'b00};
         end else begin
            state  <= DRAIN;
         end
      end else begin
         queue <= queue_nxt;
         count <= count_nxt;
         if (take) begin
            o_align <= span[1:0];
            o_ip    <= o_ip + {27'd0, i_consume_len};
         end
         if (fill) fptr <= fptr + 32'd4;
         case (state)
            IDLE: begin
               if (count_nxt < 3'd5) begin
                  state  <= FETCH;
                  o_rd   <= 1'b1;
                  o_addr <= fptr;
               end
            end
            FETCH: begin
               if (i_ready) begin
                  if (count_nxt < 3'd5) begin
                     o_addr <= fptr + 32'd4;
                  end else begin
                     state <= IDLE;
                     o_rd  <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (i_ready) begin
                  state  <= FETCH;
                  o_addr <= fptr;
               end
            end
            default: begin
               state <= IDLE;
               o_rd  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prefetch.sv
`default_nettype none
// tb_prefetch: directed self-checking bench for the prefetch queue; memory returns ~address.
module tb_prefetch;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] codebuf;
   logic [1:0]   align;
   logic         valid;
   logic [31:0]  ip;
   logic         consume;
   logic [4:0]   consume_len;
   logic         jump;
   logic [31:0]  jump_ip;
   logic [31:0]  addr;
   logic         rd;
   logic [31:0]  data;
   logic         ready;

   int errors = 0;
   int checks = 0;

   prefetch #(.RESET_IP(32'h000FFFF0)) dut (
      .clock(clock), .reset(reset), .o_codebuf(codebuf), .o_align(align),
      .o_valid(valid), .o_ip(ip), .i_consume(consume), .i_consume_len(consume_len),
      .i_jump(jump), .i_jump_ip(jump_ip), .o_addr(addr), .o_rd(rd),
      .i_data(data), .i_ready(ready)
   );

   always #5 clock = ~clock;
   assign data = ~addr;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; consume = 1'b0; consume_len = 5'd0; jump = 1'b0;
      jump_ip = 32'd0; ready = 1'b0;
      tick(); tick();
      checks++; if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", rd); end
      checks++; if (addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (codebuf !== 128'd0) begin errors++; $display("FAIL reset_codebuf: got %h want 0", codebuf); end
      checks++; if (ip !== 32'h000FFFF0) begin errors++; $display("FAIL reset_ip: got %h want 000ffff0", ip); end
      checks++; if (align !== 2'd0) begin errors++; $display("FAIL reset_align: got %0d want 0", align); end
      reset = 1'b0;
   endtask

   task automatic test_fill();
      ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (rd !== 1'b1 || addr !== 32'h000FFFF0 + 32'(4 * k)) begin
            errors++; $display("FAIL fill_addr%0d: got rd=%b addr=%h want rd=1 addr=%h", k, rd, addr, 32'h000FFFF0 + 32'(4 * k));
         end
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fill_valid_early%0d: got %b want 0", k, valid); end
      end
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b want 1", valid); end
      checks++; if (codebuf !== {~32'h000FFFFC, ~32'h000FFFF8, ~32'h000FFFF4, ~32'h000FFFF0}) begin
         errors++; $display("FAIL fill_codebuf: got %h", codebuf);
      end
      checks++; if (addr !== 32'h00100000) begin errors++; $display("FAIL fill_addr5: got %h want 00100000", addr); end
      tick();
      checks++; if (rd !== 1'b0) begin errors++; $display("FAIL fill_full_rd: got %b want 0", rd); end
      checks++; if (align !== 2'd0) begin errors++; $display("FAIL fill_align: got %0d want 0", align); end
      ready = 1'b0;
   endtask

   task automatic test_consume();
      consume = 1'b1; consume_len = 5'd3;
      tick();
      checks++; if (align !== 2'd3 || ip !== 32'h000FFFF3) begin
         errors++; $display("FAIL consume3: got align=%0d ip=%h want align=3 ip=000ffff3", align, ip);
      end
      checks++; if (codebuf !== {~32'h000FFFFC, ~32'h000FFFF8, ~32'h000FFFF4, ~32'h000FFFF0} || rd !== 1'b0) begin
         errors++; $display("FAIL consume3_nodrop: got rd=%b codebuf=%h", rd, codebuf);
      end
      consume_len = 5'd2;
      tick();
      checks++; if (align !== 2'd1 || ip !== 32'h000FFFF5) begin
         errors++; $display("FAIL consume2: got align=%0d ip=%h want align=1 ip=000ffff5", align, ip);
      end
      checks++; if (codebuf !== {~32'h00100000, ~32'h000FFFFC, ~32'h000FFFF8, ~32'h000FFFF4}) begin
         errors++; $display("FAIL consume2_drop: got %h", codebuf);
      end
      checks++; if (rd !== 1'b1 || addr !== 32'h00100004) begin
         errors++; $display("FAIL consume2_refill: got rd=%b addr=%h want rd=1 addr=00100004", rd, addr);
      end
      consume = 1'b0;
   endtask

   task automatic test_overconsume();
      consume = 1'b1; consume_len = 5'd1;
      tick();
      checks++; if (align !== 2'd2 || ip !== 32'h000FFFF6) begin
         errors++; $display("FAIL consume1: got align=%0d ip=%h want align=2 ip=000ffff6", align, ip);
      end
      consume_len = 5'd15;
      tick();
      checks++; if (align !== 2'd2 || ip !== 32'h000FFFF6 || valid !== 1'b1 ||
                    codebuf !== {~32'h00100000, ~32'h000FFFFC, ~32'h000FFFF8, ~32'h000FFFF4}) begin
         errors++; $display("FAIL consume15_ignored: got align=%0d ip=%h valid=%b", align, ip, valid);
      end
      consume_len = 5'd14;
      tick();
      checks++; if (align !== 2'd0 || ip !== 32'h00100004) begin
         errors++; $display("FAIL consume14: got align=%0d ip=%h want align=0 ip=00100004", align, ip);
      end
      checks++; if (valid !== 1'b0 || codebuf !== 128'd0) begin
         errors++; $display("FAIL consume14_drop4: got valid=%b codebuf=%h want 0", valid, codebuf);
      end
      consume = 1'b0;
   endtask

   task automatic test_consume_fill();
      ready = 1'b1;
      tick(); tick(); tick(); tick();
      checks++; if (valid !== 1'b1 || addr !== 32'h00100014) begin
         errors++; $display("FAIL refill4: got valid=%b addr=%h want valid=1 addr=00100014", valid, addr);
      end
      consume = 1'b1; consume_len = 5'd4;
      tick();
      checks++; if (codebuf !== {~32'h00100014, ~32'h00100010, ~32'h0010000C, ~32'h00100008} || valid !== 1'b1) begin
         errors++; $display("FAIL consume_fill_order: got valid=%b codebuf=%h", valid, codebuf);
      end
      checks++; if (ip !== 32'h00100008 || align !== 2'd0 || addr !== 32'h00100018) begin
         errors++; $display("FAIL consume_fill_ptrs: got ip=%h align=%0d addr=%h", ip, align, addr);
      end
      consume = 1'b0; ready = 1'b0;
   endtask

   task automatic test_jump_drain();
      jump = 1'b1; jump_ip = 32'h00001237;
      tick();
      jump = 1'b0;
      checks++; if (ip !== 32'h00001237 || align !== 2'd3 || valid !== 1'b0) begin
         errors++; $display("FAIL jump_state: got ip=%h align=%0d valid=%b", ip, align, valid);
      end
      for (int k = 0; k < 3; k++) begin
         checks++; if (rd !== 1'b1 || addr !== 32'h00100018) begin
            errors++; $display("FAIL drain_hold%0d: got rd=%b addr=%h want rd=1 addr=00100018", k, rd, addr);
         end
         if (k < 2) tick();
      end
      ready = 1'b1;
      tick();
      checks++; if (rd !== 1'b1 || addr !== 32'h00001234 || codebuf !== 128'd0) begin
         errors++; $display("FAIL drain_done: got rd=%b addr=%h codebuf=%h", rd, addr, codebuf);
      end
      tick();
      checks++; if (codebuf !== {96'd0, ~32'h00001234} || addr !== 32'h00001238) begin
         errors++; $display("FAIL jump_first: got codebuf=%h addr=%h", codebuf, addr);
      end
      checks++; if (ip !== 32'h00001237 || align !== 2'd3) begin
         errors++; $display("FAIL jump_ip_kept: got ip=%h align=%0d", ip, align);
      end
      ready = 1'b0;
   endtask

   task automatic test_reset_midread();
      reset = 1'b1;
      #1;
      checks++; if (rd !== 1'b0 || addr !== 32'd0 || valid !== 1'b0 || codebuf !== 128'd0) begin
         errors++; $display("FAIL midreset_out: got rd=%b addr=%h valid=%b codebuf=%h", rd, addr, valid, codebuf);
      end
      checks++; if (ip !== 32'h000FFFF0 || align !== 2'd0) begin
         errors++; $display("FAIL midreset_ip: got ip=%h align=%0d", ip, align);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++; if (rd !== 1'b1 || addr !== 32'h000FFFF0) begin
         errors++; $display("FAIL rerelease: got rd=%b addr=%h want rd=1 addr=000ffff0", rd, addr);
      end
   endtask

   task automatic test_jump_ready();
      ready = 1'b1; jump = 1'b1; jump_ip = 32'h00002000;
      tick();
      jump = 1'b0;
      checks++; if (rd !== 1'b1 || addr !== 32'h00002000 || valid !== 1'b0 || ip !== 32'h00002000) begin
         errors++; $display("FAIL jump_ready: got rd=%b addr=%h valid=%b ip=%h", rd, addr, valid, ip);
      end
      tick();
      checks++; if (codebuf !== {96'd0, ~32'h00002000} || addr !== 32'h00002004) begin
         errors++; $display("FAIL jump_ready_fill: got codebuf=%h addr=%h", codebuf, addr);
      end
      ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_consume();
      test_overconsume();
      test_consume_fill();
      test_jump_drain();
      test_reset_midread();
      test_jump_ready();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prefetch.md
PREFETCH -- requirements
Module: prefetch

Interface
REQ-001 SHALL have parameter RESET_IP, default 32'h000FFFF0, the linear byte address fetched first after reset.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port o_codebuf  output  128  code window; byte k on bits [8k+7:8k]; dword 0 on [31:0].
REQ-005 SHALL have port o_align  output  2  byte offset of current instruction start within dword 0.
REQ-006 SHALL have port o_valid  output  1  window holds 4 fetched dwords; o_codebuf/o_align usable.
REQ-007 SHALL have port o_ip  output  32  linear byte address of current instruction start.
REQ-008 SHALL have port i_consume  input  1  decoder retires bytes this cycle.
REQ-009 SHALL have port i_consume_len  input  5  bytes retired, 1..16.
REQ-010 SHALL have port i_jump  input  1  flush queue and restart at i_jump_ip.
REQ-011 SHALL have port i_jump_ip  input  32  new linear byte address.
REQ-012 SHALL have port o_addr  output  32  memory dword address, bits [1:0]=0.
REQ-013 SHALL have port o_rd  output  1  memory read request.
REQ-014 SHALL have port i_data  input  32  memory read data, valid when i_ready=1.
REQ-015 SHALL have port i_ready  input  1  memory completes current read this cycle.

Function
REQ-016 SHALL hold a queue of 0..5 dwords (count), a 2-bit head offset (o_align), a fetch pointer and one 3-state FSM: IDLE, FETCH, DRAIN.
REQ-017 o_codebuf SHALL be queue dwords 0..3 from head; o_valid SHALL be 1 iff count>=4; unfilled dwords read as 0.
REQ-018 Memory handshake: o_rd and o_addr SHALL stay constant from assertion until the cycle i_ready=1; i_data captured on that edge; at most one read outstanding.
REQ-019 IDLE->FETCH when count<5 (counting a dword that completes this cycle as present); FETCH->IDLE on i_ready when queue becomes full; FETCH stays FETCH (back-to-back, fetch pointer +4) on i_ready while space remains.
REQ-020 Captured dword SHALL be appended at tail; count +1; fetch pointer +4 with 32-bit wrap.
REQ-021 Consume accepted only when i_consume=1, o_valid=1, 1<=i_consume_len<=16-o_align; otherwise ignored with no state change.
REQ-022 Accepted consume: s=o_align+i_consume_len; drop s>>2 dwords from head; o_align<=s[1:0]; o_ip<=o_ip+i_consume_len (32-bit wrap).
REQ-023 Consume and fill in the same cycle SHALL both take effect: count <= count-(s>>2)+1.
REQ-024 i_jump SHALL take priority over consume and fill: count<=0, o_align<=i_jump_ip[1:0], o_ip<=i_jump_ip, fetch pointer<={i_jump_ip[31:2],2'b00}; o_valid=0 next cycle.
REQ-025 i_jump while FETCH and i_ready=0: go to DRAIN, keep o_rd/o_addr of old request until i_ready, discard that data, then FETCH from new pointer.
REQ-026 i_jump while FETCH and i_ready=1 same cycle: data discarded; next cycle FETCH at new pointer.
REQ-027 i_jump in DRAIN: update pointer/ip/align again; remain DRAIN.
REQ-028 Latency: first dword request issued the cycle after reset release or jump; o_valid rises the cycle after the 4th dword is captured.

Reset
REQ-029 On reset: count=0, o_valid=0, o_codebuf=0, FSM=IDLE, o_rd=0, o_addr=0, o_ip=RESET_IP, o_align=RESET_IP[1:0], fetch pointer={RESET_IP[31:2],2'b00}.
REQ-030 Reset mid-read SHALL drop the request immediately; the discarded response is not tracked.

Verification
REQ-031 Reset release, i_ready=1 always -> o_addr 000FFFF0, 000FFFF4, 000FFFF8, 000FFFFC; o_valid=1 one cycle after 4th capture; o_align=0; queue fills to 5 then o_rd=0.
REQ-032 Full queue, align=0, consume len=3 -> o_align=3, no dword drop, o_ip+=3; next consume len=2 -> one dword dropped, o_align=1, refill read issued.
REQ-033 i_jump_ip=32'h00001237 with read pending and i_ready delayed 3 cycles -> DRAIN keeps old o_addr; stale data discarded; next o_addr=00001234; o_align=3; o_ip=00001237.
REQ-034 Consume len=15 at align=2 (>14) -> ignored, state unchanged; len=14 -> o_align=0, 4 dwords dropped.
REQ-035 Consume and i_ready in same cycle at count=4 -> count ends at 4-(s>>2)+1, data order preserved in o_codebuf.
REQ-036 Assert reset while o_rd=1 -> o_rd=0 same cycle, all outputs at REQ-029 values.
